// File: rtl/mips_selftest_ctrl.sv
// Self-test sequencer for the single-cycle MIPS core: reset it, run it for a
// bounded number of cycles, then compare a table of registers against expected values.
`timescale 1ns/1ps

module mips_selftest_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int NUM_CHECKS   = 9,
  parameter int IDX_W        = 4,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_len,
  input  logic              halt,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [DATA_W-1:0] cfg_mask,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [ADDR_W-1:0] dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W:0]    err_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data,
  output logic [CNT_W-1:0]  cycles_run
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int               RC_W         = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST      = RC_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CHECKS - 1);
  localparam logic [IDX_W:0]   NUM_CHECKS_X = (IDX_W + 1)'(NUM_CHECKS);
  localparam logic [IDX_W:0]   ERR_MAX      = '1;
  localparam logic [IDX_W:0]   ERR_ONE      = (IDX_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d;
  logic [CNT_W-1:0]  cycles_run_q, cycles_run_d;
  logic [IDX_W-1:0]  chk_idx_q, chk_idx_d;
  logic [IDX_W:0]    err_count_q, err_count_d;
  logic [IDX_W-1:0]  first_fail_idx_q, first_fail_idx_d;
  logic [DATA_W-1:0] first_fail_data_q, first_fail_data_d;

  logic [ADDR_W-1:0]   tbl_addr_q [NUM_CHECKS];
  logic [DATA_W-1:0]   tbl_data_q [NUM_CHECKS];
  logic [DATA_W-1:0]   tbl_mask_q [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] tbl_valid_q, tbl_valid_d;

  logic tbl_we;
  logic cur_valid;
  logic mismatch;

  assign busy   = (state_q == S_RESET) || (state_q == S_RUN) || (state_q == S_CHECK);
  assign tbl_we = cfg_we && !busy && ({1'b0, cfg_idx} < NUM_CHECKS_X);

  // Unwritten entries carry X payloads; the valid bit turns them into mask-0 entries.
  assign cur_valid = tbl_valid_q[chk_idx_q];
  assign mismatch  = cur_valid && ((dbg_rdata ^ tbl_data_q[chk_idx_q]) & tbl_mask_q[chk_idx_q]) != '0;
  assign dbg_raddr = (state_q == S_CHECK && cur_valid) ? tbl_addr_q[chk_idx_q] : '0;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    tbl_valid_d = tbl_valid_q;
    if (tbl_we) tbl_valid_d[cfg_idx] = 1'b1;
  end

  always_comb begin
    state_d           = state_q;
    rst_cnt_d         = rst_cnt_q;
    run_len_d         = run_len_q;
    cycles_run_d      = cycles_run_q;
    chk_idx_d         = chk_idx_q;
    err_count_d       = err_count_q;
    first_fail_idx_d  = first_fail_idx_q;
    first_fail_data_d = first_fail_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d           = S_RESET;
          rst_cnt_d         = '0;
          run_len_d         = (run_len == '0) ? CNT_ONE : run_len;
          cycles_run_d      = '0;
          chk_idx_d         = '0;
          err_count_d       = '0;
          first_fail_idx_d  = '0;
          first_fail_data_d = '0;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RC_LAST) state_d = S_RUN;
        else                      rst_cnt_d = rst_cnt_q + RC_W'(1);
      end
      S_RUN: begin
        // The exit cycle itself is counted, hence comparing the incremented value.
        cycles_run_d = cycles_run_q + CNT_ONE;
        if (cycles_run_d == run_len_q || halt) begin
          state_d   = S_CHECK;
          chk_idx_d = '0;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_count_q == '0) begin
            first_fail_idx_d  = chk_idx_q;
            first_fail_data_d = dbg_rdata;
          end
          if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
        end
        if (chk_idx_q == IDX_LAST) state_d = S_DONE;
        else                       chk_idx_d = chk_idx_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      rst_cnt_q         <= '0;
      run_len_q         <= '0;
      cycles_run_q      <= '0;
      chk_idx_q         <= '0;
      err_count_q       <= '0;
      first_fail_idx_q  <= '0;
      first_fail_data_q <= '0;
      tbl_valid_q       <= '0;
    end else begin
      state_q           <= state_d;
      rst_cnt_q         <= rst_cnt_d;
      run_len_q         <= run_len_d;
      cycles_run_q      <= cycles_run_d;
      chk_idx_q         <= chk_idx_d;
      err_count_q       <= err_count_d;
      first_fail_idx_q  <= first_fail_idx_d;
      first_fail_data_q <= first_fail_data_d;
      tbl_valid_q       <= tbl_valid_d;
    end
  end

  // NOTE: table payload is plain storage with no reset; validity is tracked by tbl_valid_q.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_addr_q[cfg_idx] <= cfg_addr;
      tbl_data_q[cfg_idx] <= cfg_data;
      tbl_mask_q[cfg_idx] <= cfg_mask;
    end
  end

  assign cpu_rst         = (state_q == S_IDLE) || (state_q == S_RESET);
  assign cpu_en          = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_count_q == '0);
  assign err_count       = err_count_q;
  assign first_fail_idx  = first_fail_idx_q;
  assign first_fail_data = first_fail_data_q;
  assign cycles_run      = cycles_run_q;

endmodule

// File: tb/tb_mips_selftest_ctrl.sv
// Bench for mips_selftest_ctrl: a behavioural register file plus a table/run model
// predicts the result registers, latency and RUN length of every test.
`timescale 1ns/1ps

module tb_mips_selftest_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NC     = 9;
  localparam int IDX_W  = 4;
  localparam int RC     = 2;
  localparam int CNT_W  = 16;
  localparam int LIMIT  = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  run_len = '0;
  logic              halt = 1'b0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic [DATA_W-1:0] cfg_mask = '0;
  logic              cpu_rst, cpu_en, busy, done, pass;
  logic [ADDR_W-1:0] dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
  logic [IDX_W:0]    err_count;
  logic [IDX_W-1:0]  first_fail_idx;
  logic [DATA_W-1:0] first_fail_data;
  logic [CNT_W-1:0]  cycles_run;

  typedef struct packed {
    logic              done;
    logic              pass;
    logic [IDX_W:0]    err;
    logic [IDX_W-1:0]  fidx;
    logic [DATA_W-1:0] fdata;
    logic [CNT_W-1:0]  cyc;
  } res_t;

  logic [DATA_W-1:0] regs [32];
  assign dbg_rdata = regs[dbg_raddr];

  int n_tests = 0;
  int n_fail  = 0;

  bit                m_valid [NC];
  int                m_addr  [NC];
  logic [DATA_W-1:0] m_data  [NC];
  logic [DATA_W-1:0] m_mask  [NC];

  int                ref_addr [NC] = '{8, 9, 10, 11, 15, 24, 25, 16, 17};
  logic [DATA_W-1:0] ref_val  [NC] = '{5, 10, 15, 5, 2, 999, 0, 15, 1};

  mips_selftest_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NC), .IDX_W(IDX_W),
    .RESET_CYCLES(RC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len), .halt(halt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_mask(cfg_mask), .cpu_rst(cpu_rst), .cpu_en(cpu_en), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx),
    .first_fail_data(first_fail_data), .cycles_run(cycles_run)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input res_t r);
    return $sformatf("done=%b pass=%b err=%0d fidx=%0d fdata=%h cyc=%0d",
                     r.done, r.pass, r.err, r.fidx, r.fdata, r.cyc);
  endfunction

  function automatic res_t observe();
    res_t r;
    r.done = done; r.pass = pass; r.err = err_count;
    r.fidx = first_fail_idx; r.fdata = first_fail_data; r.cyc = cycles_run;
    return r;
  endfunction

  // Expected RUN length: run_len (0 means 1), cut short by the first halt cycle.
  function automatic int exp_run(input int rl, input int halt_at);
    int rl_eff = (rl == 0) ? 1 : rl;
    return (halt_at != 0 && halt_at < rl_eff) ? halt_at : rl_eff;
  endfunction

  function automatic res_t expect_res(input int r_cycles);
    res_t r;
    int   errs = 0;
    r = '0;
    r.done = 1'b1;
    for (int i = 0; i < NC; i++) begin
      if (m_valid[i] && ((regs[m_addr[i]] ^ m_data[i]) & m_mask[i]) != '0) begin
        if (errs == 0) begin
          r.fidx  = IDX_W'(i);
          r.fdata = regs[m_addr[i]];
        end
        errs++;
      end
    end
    r.err  = (errs > 31) ? 5'd31 : 5'(errs);
    r.pass = (errs == 0);
    r.cyc  = CNT_W'(r_cycles);
    return r;
  endfunction

  task automatic cfg_write(input int idx, input int addr, input logic [DATA_W-1:0] data,
                           input logic [DATA_W-1:0] mask);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_addr = ADDR_W'(addr);
    cfg_data = data; cfg_mask = mask;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (idx < NC) begin
      m_valid[idx] = 1'b1; m_addr[idx] = addr; m_data[idx] = data; m_mask[idx] = mask;
    end
  endtask

  task automatic set_ref_regs();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < NC; i++) regs[ref_addr[i]] = ref_val[i];
  endtask

  task automatic load_ref();
    for (int i = 0; i < NC; i++) cfg_write(i, ref_addr[i], ref_val[i], '1);
  endtask

  // Pulses start (plus any cfg_we already set up) and follows the test to DONE.
  task automatic do_run(input int rl, input int halt_at, input bit disturb,
                        output int lat, output int en_cyc);
    run_len = CNT_W'(rl);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    lat = 0; en_cyc = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      halt = (halt_at != 0 && lat == RC + halt_at - 1);
      if (disturb && lat == RC + 1) begin
        start = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_addr = 5'd8;
        cfg_data = 32'hdead; cfg_mask = '1;
      end
      if (cpu_en === 1'b1) en_cyc++;
      @(posedge clk); #1;
      lat++;
      start = 1'b0; cfg_we = 1'b0;
    end
    halt = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
    set_ref_regs();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({cpu_rst, cpu_en, busy, done, pass} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rst/en/busy/done/pass=%b want 10000",
               {cpu_rst, cpu_en, busy, done, pass});
    end
    n_tests++;
    if ({err_count, first_fail_idx, first_fail_data, cycles_run, dbg_raddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_results: got err=%0d fidx=%0d fdata=%h cyc=%0d raddr=%0d want all 0",
               err_count, first_fail_idx, first_fail_data, cycles_run, dbg_raddr);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({cpu_rst, busy, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rst/busy/done=%b want 100", {cpu_rst, busy, done});
    end
  endtask

  task automatic test_program();
    int    rl, h, lat, en_cyc, r;
    string nm;
    res_t  exp_r;
    for (int s = 0; s < 5; s++) begin
      set_ref_regs();
      load_ref();
      rl = 20; h = 0;
      case (s)
        0: nm = "ref_pass";
        1: begin nm = "entry3_wrong"; cfg_write(3, 11, 6, '1); end
        2: begin
          nm = "entry5_masked";
          cfg_write(3, 11, 6, '1);
          cfg_write(5, 24, 1000, '0);
        end
        3: begin nm = "halt_cycle7"; rl = 100; h = 7; end
        default: begin nm = "runlen0_drop"; rl = 0; cfg_write(NC, 8, 7, '1); end
      endcase
      r = exp_run(rl, h);
      do_run(rl, h, 1'b0, lat, en_cyc);
      exp_r = expect_res(r);
      n_tests++;
      if (observe() !== exp_r) begin
        n_fail++;
        $display("FAIL %s result: got %s want %s", nm, fmt(observe()), fmt(exp_r));
      end
      n_tests++;
      if (lat != RC + r + NC) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", nm, lat, RC + r + NC);
      end
      n_tests++;
      if (en_cyc != r) begin
        n_fail++;
        $display("FAIL %s run_cycles: got %0d want %0d", nm, en_cyc, r);
      end
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (observe() !== exp_r || cpu_rst !== 1'b0 || cpu_en !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_hold: got %s rst=%b en=%b want %s rst=0 en=0",
                 nm, fmt(observe()), cpu_rst, cpu_en, fmt(exp_r));
      end
    end
  endtask

  task automatic test_busy_ignore();
    int   lat, en_cyc;
    res_t exp_r;
    set_ref_regs();
    load_ref();
    do_run(20, 0, 1'b1, lat, en_cyc);
    exp_r = expect_res(20);
    n_tests++;
    if (observe() !== exp_r) begin
      n_fail++;
      $display("FAIL busy_ignore result: got %s want %s", fmt(observe()), fmt(exp_r));
    end
    n_tests++;
    if (lat != RC + 20 + NC || en_cyc != 20) begin
      n_fail++;
      $display("FAIL busy_ignore timing: got lat=%0d run=%0d want lat=%0d run=20",
               lat, en_cyc, RC + 20 + NC);
    end
  endtask

  task automatic test_rst_mid_check();
    int   lat, en_cyc;
    res_t exp_r;
    set_ref_regs();
    load_ref();
    run_len = CNT_W'(20);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (lat < RC + 20 + 3) begin
      @(posedge clk); #1;
      lat++;
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({cpu_rst, cpu_en, busy, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_mid_check: got rst/en/busy/done=%b want 1000",
               {cpu_rst, cpu_en, busy, done});
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({cpu_rst, busy, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_no_done: got rst/busy/done=%b want 100", {cpu_rst, busy, done});
    end
    do_run(20, 0, 1'b0, lat, en_cyc);
    exp_r = expect_res(20);
    n_tests++;
    if (observe() !== exp_r || lat != RC + 20 + NC) begin
      n_fail++;
      $display("FAIL rerun_after_rst: got %s lat=%0d want %s lat=%0d",
               fmt(observe()), lat, fmt(exp_r), RC + 20 + NC);
    end
  endtask

  task automatic test_back_to_back();
    int   lat, en_cyc;
    res_t exp_r;
    // In DONE from the previous test: write entry 3 in the same cycle as start.
    cfg_we = 1'b1; cfg_idx = 4'd3; cfg_addr = 5'd11; cfg_data = 32'd6; cfg_mask = '1;
    m_data[3] = 32'd6; m_mask[3] = '1; m_addr[3] = 11; m_valid[3] = 1'b1;
    do_run(12, 0, 1'b0, lat, en_cyc);
    exp_r = expect_res(12);
    n_tests++;
    if (observe() !== exp_r) begin
      n_fail++;
      $display("FAIL back_to_back result: got %s want %s", fmt(observe()), fmt(exp_r));
    end
    n_tests++;
    if (lat != RC + 12 + NC) begin
      n_fail++;
      $display("FAIL back_to_back latency: got %0d want %0d", lat, RC + 12 + NC);
    end
  endtask

  task automatic test_random();
    int                rl, h, a, lat, en_cyc, r;
    logic [DATA_W-1:0] d, m;
    res_t              exp_r;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      for (int i = 0; i < NC; i++) begin
        a = $urandom_range(0, 31);
        case ($urandom_range(0, 2))
          0:       d = regs[a];
          1:       d = $urandom;
          default: d = regs[a] ^ (32'd1 << $urandom_range(0, 31));
        endcase
        case ($urandom_range(0, 2))
          0:       m = '1;
          1:       m = '0;
          default: m = $urandom;
        endcase
        cfg_write(i, a, d, m);
      end
      cfg_write($urandom_range(NC, 15), 0, $urandom, '1);
      rl = $urandom_range(0, 40);
      h  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 45);
      r  = exp_run(rl, h);
      do_run(rl, h, 1'b0, lat, en_cyc);
      exp_r = expect_res(r);
      n_tests++;
      if (observe() !== exp_r) begin
        n_fail++;
        $display("FAIL random%0d result: got %s want %s", it, fmt(observe()), fmt(exp_r));
      end
      n_tests++;
      if (lat != RC + r + NC || en_cyc != r) begin
        n_fail++;
        $display("FAIL random%0d timing: got lat=%0d run=%0d want lat=%0d run=%0d",
                 it, lat, en_cyc, RC + r + NC, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_busy_ignore();
    test_rst_mid_check();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
